uart_rx_display: RTL and testbench

Serial receive end paired with the board's UART transmitter. The block samples `rx` at mid-bit and deframes 8N1 bytes, LSB first. Each accepted byte is published on parallel outputs `t0`..`t7` together with a one-cycle `trecieve` strobe. The last byte and a running receive count are shown in hex on the multiplexed 4-digit seven-segment display. A framing error drops the byte, pulses `ferr`, and waits for line idle before the next frame is accepted.

---
 rtl/uart_rx_display.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_display.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_display.sv
// 8N1 UART receiver with mid-bit sampling, framing-error recovery and a
// multiplexed 4-digit hex display of the last byte and the receive count.
module uart_rx_display #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DIGIT_TICKS  = 50000
) (
    input  logic clk_raw,
    input  logic rst_n,
    input  logic rx,
    input  logic pb5_raw,
    output logic t0,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic t4,
    output logic t5,
    output logic t6,
    output logic t7,
    output logic trecieve,
    output logic ferr,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic numsl0,
    output logic numsl1,
    output logic numsl2,
    output logic numsl3
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int REF_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(DIGIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    logic             rx_meta;
    logic             rx_sync;
    logic             pb_meta;
    logic             pb_sync;
    logic             pb_prev;
    logic             clr;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       t_reg;
    logic [7:0]       count;
    logic             recv_r;
    logic             ferr_r;
    logic [REF_W-1:0] refresh;
    logic [1:0]       digit_idx;
    logic [1:0]       next_idx;
    logic             ref_wrap;
    logic [3:0]       nibble;
    logic [3:0]       sel_n;
    logic [6:0]       seg_n;

    // Active-low {a,b,c,d,e,f,g} hex glyphs.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b0000001;
            4'h1: r = 7'b1001111;
            4'h2: r = 7'b0010010;
            4'h3: r = 7'b0000110;
            4'h4: r = 7'b1001100;
            4'h5: r = 7'b0100100;
            4'h6: r = 7'b0100000;
            4'h7: r = 7'b0001111;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0000100;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b1100000;
            4'hC: r = 7'b0110001;
            4'hD: r = 7'b1000010;
            4'hE: r = 7'b0110000;
            default: r = 7'b0111000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            pb_meta <= 1'b0;
            pb_sync <= 1'b0;
            pb_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            pb_meta <= pb5_raw;
            pb_sync <= pb_meta;
            pb_prev <= pb_sync;
        end
    end

    assign clr = pb_sync & ~pb_prev;

    // Data bits arrive LSB first, so each new bit enters at the MSB.
    always_ff @(posedge clk_raw) begin
        if (state == DATA && bit_cnt == BIT_LAST) begin
            shift <= {rx_sync, shift[7:1]};
        end
    end

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            t_reg    <= 8'h00;
            count    <= 8'h00;
            recv_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            recv_r <= 1'b0;
            ferr_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_sync) begin
                            if (!clr) begin
                                t_reg  <= shift;
                                count  <= count + 8'd1;
                                recv_r <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            ferr_r <= 1'b1;
                            state  <= WAITHI;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                WAITHI: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A button clear overrides any byte accepted in the same cycle.
            if (clr) begin
                t_reg <= 8'h00;
                count <= 8'h00;
            end
        end
    end

    always_comb begin
        ref_wrap = (refresh == REF_LAST);
        next_idx = ref_wrap ? digit_idx + 2'd1 : digit_idx;
        case (next_idx)
            2'd0:    nibble = t_reg[3:0];
            2'd1:    nibble = t_reg[7:4];
            2'd2:    nibble = count[3:0];
            default: nibble = count[7:4];
        endcase
    end

    // Select and glyph are registered from the same next index so they switch together.
    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            refresh   <= '0;
            digit_idx <= 2'd0;
            sel_n     <= 4'b1110;
            seg_n     <= 7'b0000001;
        end else begin
            refresh   <= ref_wrap ? '0 : refresh + REF_W'(1);
            digit_idx <= next_idx;
            sel_n     <= ~(4'b0001 << next_idx);
            seg_n     <= hex_glyph(nibble);
        end
    end

    assign {t7, t6, t5, t4, t3, t2, t1, t0}     = t_reg;
    assign trecieve                             = recv_r;
    assign ferr                                 = ferr_r;
    assign {a, b, c, d, e, f, g}                = seg_n;
    assign {numsl3, numsl2, numsl1, numsl0}     = sel_n;

endmodule

// File: tb/tb_uart_rx_display.sv
// Bench for uart_rx_display: table-driven frames, corner sequences and
// random frames checked against a queue/arithmetic reference model.
module tb_uart_rx_display;

    localparam int C = 16;
    localparam int D = 4;

    logic clk_raw = 1'b0;
    logic rst_n   = 1'b0;
    logic rx      = 1'b1;
    logic pb5_raw = 1'b0;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic trecieve, ferr;
    logic a, b, c, d, e, f, g;
    logic numsl0, numsl1, numsl2, numsl3;

    logic [7:0] tv;
    logic [6:0] seg;
    logic [3:0] sel;

    assign tv  = {t7, t6, t5, t4, t3, t2, t1, t0};
    assign seg = {a, b, c, d, e, f, g};
    assign sel = {numsl3, numsl2, numsl1, numsl0};

    uart_rx_display #(.CLKS_PER_BIT(C), .DIGIT_TICKS(D)) dut (
        .clk_raw(clk_raw), .rst_n(rst_n), .rx(rx), .pb5_raw(pb5_raw),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
        .trecieve(trecieve), .ferr(ferr),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .numsl0(numsl0), .numsl1(numsl1), .numsl2(numsl2), .numsl3(numsl3)
    );

    always #5 clk_raw = ~clk_raw;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk_raw) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lit segments of each hex glyph, by letter.
    string glyph_s [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph_exp(input logic [3:0] v);
        logic [6:0] r;
        string s;
        r = 7'h7F;
        s = glyph_s[v];
        for (int i = 0; i < s.len(); i++) begin
            int k;
            k = int'(s[i]) - 97;
            r[6-k] = 1'b0;
        end
        return r;
    endfunction

    // Reference model: queue of bytes expected on trecieve, plus pulse tallies.
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    int last_rx_cyc = 0;
    logic rx_prev = 1'b0;
    logic ferr_prev = 1'b0;

    always @(negedge clk_raw) begin
        if (rst_n) begin
            if (trecieve) begin
                rx_cnt++;
                last_rx_cyc = cyc;
                if (q.size() == 0) begin
                    check("spurious_trecieve", 32'd1, 32'd0);
                end else begin
                    exp_b = q.pop_front();
                    check("t_on_strobe", 32'(tv), 32'(exp_b));
                end
                if (rx_prev) check("trecieve_width", 32'd2, 32'd1);
            end
            if (ferr) begin
                ferr_cnt++;
                if (ferr_prev) check("ferr_width", 32'd2, 32'd1);
            end
            rx_prev   = trecieve;
            ferr_prev = ferr;
        end
    end

    task automatic send_byte(input logic [7:0] data, input bit stop_ok);
        if (stop_ok) q.push_back(data);
        rx = 1'b0;
        repeat (C) @(negedge clk_raw);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (C) @(negedge clk_raw);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (C) @(negedge clk_raw);
        end else begin
            rx = 1'b0;
            repeat (3 * C) @(negedge clk_raw);
            rx = 1'b1;
            repeat (2 * C) @(negedge clk_raw);
        end
    endtask

    task automatic check_disp(input logic [7:0] et, input logic [7:0] ec, input string nm);
        logic [3:0] nib;
        for (int i = 0; i < 4 * D + 2; i++) begin
            @(negedge clk_raw);
            case (sel)
                4'b1110: nib = et[3:0];
                4'b1101: nib = et[7:4];
                4'b1011: nib = ec[3:0];
                4'b0111: nib = ec[7:4];
                default: begin
                    nib = 4'h0;
                    check({nm, "_numsl"}, 32'(sel), 32'hE);
                end
            endcase
            check({nm, "_seg"}, 32'(seg), 32'(glyph_exp(nib)));
        end
    endtask

    task automatic press_pb5();
        pb5_raw = 1'b1;
        repeat (3) @(negedge clk_raw);
        pb5_raw = 1'b0;
        repeat (4) @(negedge clk_raw);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        logic [7:0] exp_t;
        logic [7:0] exp_cnt;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] mdl_t;
    logic [7:0] mdl_cnt;

    initial begin
        int r0, f0, start_cyc, last_idx, run, cur_idx;
        logic [7:0] rb;
        bit ok;

        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 8'd1, 0};
        tbl[1] = '{8'h3C, 1'b0, 8'hA5, 8'd1, 1};
        tbl[2] = '{8'h01, 1'b1, 8'h01, 8'd2, 0};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF, 8'd3, 0};
        tbl[4] = '{8'h00, 1'b1, 8'h00, 8'd4, 0};

        // Reset state
        repeat (3) @(negedge clk_raw);
        check("rst_t", 32'(tv), 32'h00);
        check("rst_trecieve", 32'(trecieve), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_numsl", 32'(sel), 32'hE);
        check("rst_seg", 32'(seg), 32'b0000001);
        rst_n = 1'b1;

        // Idle: digit rotation every D cycles, all digits show 0
        last_idx = -1;
        run = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_raw);
            case (sel)
                4'b1110: cur_idx = 0;
                4'b1101: cur_idx = 1;
                4'b1011: cur_idx = 2;
                4'b0111: cur_idx = 3;
                default: begin
                    cur_idx = -1;
                    check("idle_numsl", 32'(sel), 32'hE);
                end
            endcase
            if (cur_idx != last_idx) begin
                if (last_idx >= 0 && run > 0 && i > D) begin
                    check("idle_run_len", 32'(run), 32'(D));
                    check("idle_next_digit", 32'(cur_idx), 32'((last_idx + 1) % 4));
                end
                run = 1;
                last_idx = cur_idx;
            end else begin
                run++;
            end
            if (i % 10 == 0) check("idle_seg", 32'(seg), 32'(glyph_exp(4'h0)));
        end
        check("idle_t", 32'(tv), 32'h00);
        check("idle_rx_cnt", 32'(rx_cnt), 32'd0);
        check("idle_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            r0 = rx_cnt;
            f0 = ferr_cnt;
            start_cyc = cyc;
            send_byte(tbl[i].data, tbl[i].stop_ok);
            check("tbl_t", 32'(tv), 32'(tbl[i].exp_t));
            check("tbl_ferr", 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
            check("tbl_rx", 32'(rx_cnt - r0), 32'(tbl[i].stop_ok ? 1 : 0));
            if (i == 0) check("rx_latency", 32'(last_rx_cyc - start_cyc), 32'(2 + C / 2 + 9 * C + 1));
            check_disp(tbl[i].exp_t, tbl[i].exp_cnt, "tbl_disp");
        end
        mdl_t = 8'h00;
        mdl_cnt = 8'd4;

        // Short glitch on idle line
        r0 = rx_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk_raw);
        rx = 1'b1;
        repeat (40) @(negedge clk_raw);
        check("glitch_rx", 32'(rx_cnt - r0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'h5A, 1'b1);
        mdl_t = 8'h5A;
        mdl_cnt = mdl_cnt + 8'd1;
        check("glitch_after_t", 32'(tv), 32'(mdl_t));
        check_disp(mdl_t, mdl_cnt, "glitch_disp");

        // Clear pressed while 0x7E is in flight
        r0 = rx_cnt;
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (60) @(negedge clk_raw);
                press_pb5();
                check("clr_mid_t", 32'(tv), 32'h00);
                check_disp(8'h00, 8'h00, "clr_mid_disp");
            end
        join
        mdl_t = 8'h7E;
        mdl_cnt = 8'd1;
        check("clr_rx", 32'(rx_cnt - r0), 32'd1);
        check("clr_after_t", 32'(tv), 32'(mdl_t));
        check_disp(mdl_t, mdl_cnt, "clr_after_disp");

        // 256 back-to-back 0x55 frames wrap the count to zero
        press_pb5();
        check("pre_wrap_t", 32'(tv), 32'h00);
        r0 = rx_cnt;
        for (int i = 0; i < 256; i++) send_byte(8'h55, 1'b1);
        check("wrap_rx", 32'(rx_cnt - r0), 32'd256);
        check("wrap_t", 32'(tv), 32'h55);
        check_disp(8'h55, 8'h00, "wrap_disp");
        mdl_t = 8'h55;
        mdl_cnt = 8'h00;

        // Random frames, some with a broken stop bit
        for (int i = 0; i < 30; i++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            f0 = ferr_cnt;
            send_byte(rb, ok);
            if (ok) begin
                mdl_t = rb;
                mdl_cnt = mdl_cnt + 8'd1;
            end
            check("rnd_t", 32'(tv), 32'(mdl_t));
            check("rnd_ferr", 32'(ferr_cnt - f0), 32'(ok ? 0 : 1));
            if (i % 3 == 0) check_disp(mdl_t, mdl_cnt, "rnd_disp");
            repeat ($urandom_range(0, 5)) @(negedge clk_raw);
        end

        repeat (20) @(negedge clk_raw);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
